// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: FSM states, instruction size, NOP word and PC alignment.
// Imported by the fetch top, its PC register and the fetch interface users.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES   = 32'd4;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the IF/ID-facing outputs.
// master = fetch unit, slave = memory and IF/ID side.
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fetch_valid;
    logic [31:0] instr;
    logic [31:0] next_four_add;

    modport master (
        output imem_req_valid, imem_addr, fetch_valid, instr, next_four_add,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_addr, fetch_valid, instr, next_four_add,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit_fetch_pc_reg.sv
// PC register: reset > redirect load (word-aligned) > increment by one instruction > hold.
// Single-cycle update; no backpressure of its own.
module fetch_pc_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic        inc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = align_pc(load_pc_i);
        end else if (inc_i) begin
            pc_d = pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= align_pc(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: one outstanding imem request, buffers the word for IF/ID,
// holds it under stall, and on redirect reloads the PC and drains any stale in-flight response.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_target,
    if_fetch_unit_if.master        bus,
    output logic [31:0]            pc
);

    fetch_state_e state_q;
    logic [31:0]  instr_q;
    logic         pc_inc;

    // Only a consumed instruction advances the PC; a redirect always wins.
    assign pc_inc = (state_q == S_HOLD) && !redirect_valid && !stall;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (redirect_valid),
        .load_pc_i (redirect_target),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            instr_q <= NOP_INSTR;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (!redirect_valid && bus.imem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        // A response arriving with the redirect is already drained.
                        state_q <= bus.imem_rsp_valid ? S_REQ : S_DROP;
                    end else if (bus.imem_rsp_valid) begin
                        instr_q <= bus.imem_rsp_data;
                        state_q <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if (bus.imem_rsp_valid) begin
                        state_q <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || !stall) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign bus.imem_req_valid = !reset && (state_q == S_REQ) && !redirect_valid;
    assign bus.imem_addr      = pc;
    assign bus.fetch_valid    = !reset && (state_q == S_HOLD) && !redirect_valid;
    assign bus.instr          = instr_q;
    assign bus.next_four_add  = pc + INSTR_BYTES;

endmodule
